// File: rtl/priv_plic_lite_pkg.sv
// Shared types and register map for the lightweight platform interrupt controller.
// Privilege encodings follow the mstatus.MPP layout.
package priv_plic_lite_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLAIMED = 2'd2
  } plic_state_t;

  localparam logic [7:0] ADDR_PRIO_BASE = 8'h00;
  localparam logic [7:0] ADDR_ENABLE    = 8'h40;
  localparam logic [7:0] ADDR_DELEG     = 8'h41;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h42;
  localparam logic [7:0] ADDR_PENDING   = 8'h43;
  localparam logic [7:0] ADDR_CLAIM     = 8'h44;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/priv_plic_prio_sel.sv
// Combinational arbiter: picks the eligible source with the highest priority,
// lowest ID on ties, and reports the mode it is delegated to.
module priv_plic_prio_sel #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC:1]             elig,
  input  logic [NUM_SRC:1][PRIO_W-1:0] prio,
  input  logic [NUM_SRC:1]             deleg,
  output logic                         valid,
  output logic [ID_W-1:0]              id,
  output logic                         target
);

  logic [PRIO_W-1:0] best;

  // Strict greater-than while scanning upward keeps the lowest ID on ties.
  always_comb begin
    valid  = 1'b0;
    id     = '0;
    target = 1'b0;
    best   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (elig[i] && (!valid || prio[i] > best)) begin
        valid  = 1'b1;
        best   = prio[i];
        id     = ID_W'(i);
        target = deleg[i];
      end
    end
  end

endmodule

// File: rtl/priv_1_12_plic_lite.sv
// Platform interrupt controller: per-source gateways, priority/threshold gating,
// M/S delegation and a claim/complete handshake toward the priv unit.
module priv_1_12_plic_lite
  import priv_plic_lite_pkg::*;
#(
  parameter int                 NUM_SRC    = 16,
  parameter int                 PRIO_W     = 3,
  parameter logic [NUM_SRC-1:0] LEVEL_MASK = '0,
  localparam int                ID_W       = $clog2(NUM_SRC + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [1:0]         curr_priv,
  input  logic               m_ie,
  input  logic               s_ie,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               intr_req,
  output logic               intr_target,
  output logic [ID_W-1:0]    intr_id,
  input  logic               intr_ack
);

  logic [NUM_SRC:1][PRIO_W-1:0] prio_q;
  logic [NUM_SRC:1]             enable_q, deleg_q, pending_q, in_service_q;
  logic [NUM_SRC:1]             pending_n, in_service_n, elig;
  logic [NUM_SRC-1:0]           src_prev_q;
  logic [PRIO_W-1:0]            thr_q;

  plic_state_t     state_q, state_n;
  logic [ID_W-1:0] held_id_q, held_id_n, claimed_id_q, claimed_id_n;
  logic            held_tgt_q, held_tgt_n;
  logic            held_elig, claim, complete, m_ok, s_ok;
  logic            sel_valid, sel_tgt;
  logic [ID_W-1:0] sel_id;

  assign claim    = (state_q == REQ) && intr_ack;
  assign complete = cfg_we && (cfg_addr == ADDR_CLAIM) && (state_q == CLAIMED) &&
                    (cfg_wdata == 32'(claimed_id_q));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prio_q   <= '0;
      enable_q <= '0;
      deleg_q  <= '0;
      thr_q    <= '0;
    end else if (cfg_we) begin
      for (int i = 1; i <= NUM_SRC; i++)
        if (cfg_addr == ADDR_PRIO_BASE + 8'(i)) prio_q[i] <= cfg_wdata[PRIO_W-1:0];
      if (cfg_addr == ADDR_ENABLE)    enable_q <= cfg_wdata[NUM_SRC:1];
      if (cfg_addr == ADDR_DELEG)     deleg_q  <= cfg_wdata[NUM_SRC:1];
      if (cfg_addr == ADDR_THRESHOLD) thr_q    <= cfg_wdata[PRIO_W-1:0];
    end
  end

  // Gateways: a rising edge in the ack cycle re-arms pending; level sources
  // stop tracking their line while in service.
  always_comb begin
    pending_n    = '0;
    in_service_n = in_service_q;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (LEVEL_MASK[i-1])
        pending_n[i] = (claim && held_id_q == ID_W'(i)) ? 1'b0 :
                       (in_service_q[i] ? pending_q[i] : src_irq[i-1]);
      else
        pending_n[i] = (pending_q[i] && !(claim && held_id_q == ID_W'(i))) ||
                       (src_irq[i-1] && !src_prev_q[i-1]);
      if (claim && held_id_q == ID_W'(i))         in_service_n[i] = 1'b1;
      if (complete && claimed_id_q == ID_W'(i))  in_service_n[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending_q    <= '0;
      in_service_q <= '0;
      src_prev_q   <= '0;
    end else begin
      pending_q    <= pending_n;
      in_service_q <= in_service_n;
      src_prev_q   <= src_irq;
    end
  end

  assign m_ok = (curr_priv != PRIV_M) || m_ie;
  assign s_ok = (curr_priv == PRIV_U) || ((curr_priv == PRIV_S) && s_ie);

  always_comb begin
    elig      = '0;
    held_elig = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      elig[i] = pending_q[i] && enable_q[i] && (prio_q[i] > thr_q) &&
                (prio_q[i] != '0) && (deleg_q[i] ? s_ok : m_ok);
      if (held_id_q == ID_W'(i)) held_elig = elig[i];
    end
  end

  priv_plic_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_sel (
    .elig   (elig),
    .prio   (prio_q),
    .deleg  (deleg_q),
    .valid  (sel_valid),
    .id     (sel_id),
    .target (sel_tgt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      held_id_q    <= '0;
      held_tgt_q   <= 1'b0;
      claimed_id_q <= '0;
    end else begin
      state_q      <= state_n;
      held_id_q    <= held_id_n;
      held_tgt_q   <= held_tgt_n;
      claimed_id_q <= claimed_id_n;
    end
  end

  // Ack beats retraction: the priv unit already took the trap on this request.
  always_comb begin
    state_n      = state_q;
    held_id_n    = held_id_q;
    held_tgt_n   = held_tgt_q;
    claimed_id_n = claimed_id_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_n    = REQ;
          held_id_n  = sel_id;
          held_tgt_n = sel_tgt;
        end
      end
      REQ: begin
        if (intr_ack) begin
          state_n      = CLAIMED;
          claimed_id_n = held_id_q;
        end else if (!held_elig) begin
          state_n = IDLE;
        end
      end
      CLAIMED: begin
        if (complete) begin
          state_n      = IDLE;
          claimed_id_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    intr_req    = (state_q == REQ);
    intr_id     = intr_req ? held_id_q : '0;
    intr_target = intr_req && held_tgt_q;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata[NUM_SRC:0] = {enable_q, 1'b0};
      ADDR_DELEG:     cfg_rdata[NUM_SRC:0] = {deleg_q, 1'b0};
      ADDR_THRESHOLD: cfg_rdata[PRIO_W-1:0] = thr_q;
      ADDR_PENDING:   cfg_rdata[NUM_SRC:0] = {pending_q, 1'b0};
      ADDR_CLAIM:     if (state_q == CLAIMED) cfg_rdata[ID_W-1:0] = claimed_id_q;
      default: begin
        for (int i = 1; i <= NUM_SRC; i++)
          if (cfg_addr == ADDR_PRIO_BASE + 8'(i)) cfg_rdata[PRIO_W-1:0] = prio_q[i];
      end
    endcase
  end

endmodule
